// File: rtl/demux_pkg.sv
// rtl/demux_pkg.sv - shared constants and helpers for the demux_n family
//
// Purpose: holds the supported lane-count range, the legality check for
//          WAYS and the select-width function used by demux_n and its
//          one-hot decoder.
// Ports:   none (package).
package demux_pkg;

  localparam int DEMUX_MIN_WAYS = 2;
  localparam int DEMUX_MAX_WAYS = 8;

  // True when a lane count is inside the supported range.
  function automatic bit demux_ways_ok(input int ways);
    return (ways >= DEMUX_MIN_WAYS) && (ways <= DEMUX_MAX_WAYS);
  endfunction

  // Select width for a given lane count; never narrower than one bit.
  function automatic int demux_sel_w(input int ways);
    int w;
    w = 1;
    while ((1 << w) < ways) w++;
    return w;
  endfunction

endpackage

// File: rtl/demux_onehot_dec.sv
// rtl/demux_onehot_dec.sv - binary select to one-hot lane enable decoder
//
// Purpose: turns a binary lane select into a WAYS-bit one-hot enable.
//          Selects at or above WAYS produce an all-zero enable.
// Ports:   sel - binary lane select (SEL_W bits)
//          en  - one-hot lane enable (WAYS bits), bit i set when sel == i
module demux_onehot_dec
  import demux_pkg::*;
#(
  parameter int WAYS  = 4,
  parameter int SEL_W = demux_sel_w(WAYS)
) (
  input  logic [SEL_W-1:0] sel,
  output logic [WAYS-1:0]  en
);

  // Only indices below WAYS get an enable bit, so out-of-range selects
  // fall through to the all-zero default.
  always_comb begin
    en = '0;
    for (int i = 0; i < WAYS; i++) begin
      if (sel == SEL_W'(i)) en[i] = 1'b1;
    end
  end

endmodule

// File: rtl/demux_n.sv
// rtl/demux_n.sv - parameterised 1-to-N demultiplexer (2 to 8 lanes)
//
// Purpose: steers a onto the lane chosen by sel; every other lane is zero.
//          Optional output register stage selected by macro
//          DEMUX_N_OUT_REG_EN (defined: 1-cycle latency with async clear;
//          undefined: combinational, rst_n gates the lanes to zero).
// Ports:   clk   - clock, used only by the register stage
//          rst_n - asynchronous active-low reset, forces y to zero
//          a     - data to route (DATA_W bits)
//          sel   - binary lane select, 0 selects lane 0
//          y     - packed lanes, lane i is y[i*DATA_W +: DATA_W]
module demux_n
  import demux_pkg::*;
#(
  parameter int WAYS   = 4,
  parameter int SEL_W  = demux_sel_w(WAYS),
  parameter int DATA_W = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [DATA_W-1:0]      a,
  input  logic [SEL_W-1:0]       sel,
  output logic [WAYS*DATA_W-1:0] y
);

  if (!demux_ways_ok(WAYS)) begin : g_bad_ways
    $fatal(1, "demux_n: WAYS=%0d outside supported range 2..8", WAYS);
  end
  if (SEL_W != demux_sel_w(WAYS)) begin : g_bad_sel_w
    $fatal(1, "demux_n: SEL_W=%0d must equal derived width %0d",
           SEL_W, demux_sel_w(WAYS));
  end

  logic [WAYS-1:0]        en;
  logic [WAYS*DATA_W-1:0] y_dec;

  demux_onehot_dec #(
    .WAYS  (WAYS),
    .SEL_W (SEL_W)
  ) u_dec (
    .sel (sel),
    .en  (en)
  );

  for (genvar i = 0; i < WAYS; i++) begin : g_lane
    assign y_dec[i*DATA_W +: DATA_W] = a & {DATA_W{en[i]}};
  end

`ifdef DEMUX_N_OUT_REG_EN
  // a and sel are decoded together before the edge, so one capture always
  // holds a consistent lane pattern.
  logic [WAYS*DATA_W-1:0] y_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) y_q <= '0;
    else        y_q <= y_dec;
  end

  assign y = y_q;
`else
  assign y = rst_n ? y_dec : '0;
`endif

endmodule

// File: tb/tb_demux_n.sv
// tb/tb_demux_n.sv - self-checking bench for demux_n (2, 4, 6 and 8 lanes)
module tb_demux_n;

  logic clk = 1'b0;
  logic rst_n;

  logic       a2, a4, a8;
  logic [3:0] a6;
  logic       s2;
  logic [1:0] s4;
  logic [2:0] s8, s6;
  logic [1:0]  y2;
  logic [3:0]  y4;
  logic [7:0]  y8;
  logic [23:0] y6;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  demux_n #(.WAYS(2), .DATA_W(1)) u2 (.clk(clk), .rst_n(rst_n), .a(a2), .sel(s2), .y(y2));
  demux_n #(.WAYS(4), .DATA_W(1)) u4 (.clk(clk), .rst_n(rst_n), .a(a4), .sel(s4), .y(y4));
  demux_n #(.WAYS(8), .DATA_W(1)) u8 (.clk(clk), .rst_n(rst_n), .a(a8), .sel(s8), .y(y8));
  demux_n #(.WAYS(6), .DATA_W(4)) u6 (.clk(clk), .rst_n(rst_n), .a(a6), .sel(s6), .y(y6));

  // Reference lane pattern: a shifted into the slot of the selected lane.
  function automatic logic [31:0] model(input int ways, input int dw,
                                        input logic [3:0] av, input int s);
    logic [31:0] m;
    m = (32'd1 << dw) - 32'd1;
    if (s >= ways) return 32'd0;
    return (32'(av) & m) << (s * dw);
  endfunction

  task automatic push(input logic [31:0] v);
    exp_q.push_back(v);
  endtask

  task automatic check(input string tag, input logic [31:0] obs);
    logic [31:0] e;
    n_tests++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $error("FAIL %s observed=%h expected=<empty scoreboard>", tag, obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e) else begin
        n_fail++;
        $error("FAIL %s observed=%h expected=%h", tag, obs, e);
      end
    end
  endtask

  // Wait until the outputs reflect the inputs just driven.
  task automatic settle();
`ifdef DEMUX_N_OUT_REG_EN
    @(posedge clk);
    #1;
`else
    #1;
`endif
  endtask

  initial begin
    rst_n = 1'b0;
    a2 = 1'b1; s2 = 1'b0;
    a4 = 1'b1; s4 = 2'd1;
    a8 = 1'b1; s8 = 3'd5;
    a6 = 4'hA; s6 = 3'd3;
    repeat (2) @(posedge clk);
    #1;
    push(32'd0); check("reset_y2", 32'(y2));
    push(32'd0); check("reset_y4", 32'(y4));
    push(32'd0); check("reset_y8", 32'(y8));
    push(32'd0); check("reset_y6", 32'(y6));
    rst_n = 1'b1;

    // 2 lanes: a toggles every other step, sel every step.
    for (int t = 0; t < 10; t++) begin
      a2 = 1'((t / 2) % 2);
      s2 = 1'(t % 2);
      push({30'd0, a2 & s2, a2 & ~s2});
      settle();
      check($sformatf("w2_t%0d", t), 32'(y2));
    end

    // 4 lanes: explicit one-hot patterns, then a=0 sweep.
    a4 = 1'b1;
    for (int s = 0; s < 4; s++) begin
      s4 = 2'(s);
      push(32'd1 << s);
      settle();
      check($sformatf("w4_a1_s%0d", s), 32'(y4));
    end
    a4 = 1'b0;
    for (int s = 0; s < 4; s++) begin
      s4 = 2'(s);
      push(32'd0);
      settle();
      check($sformatf("w4_a0_s%0d", s), 32'(y4));
    end

    // 8 lanes: exhaustive a x sel.
    for (int av = 0; av < 2; av++) begin
      for (int s = 0; s < 8; s++) begin
        a8 = 1'(av);
        s8 = 3'(s);
        push(model(8, 1, 4'(av), s));
        settle();
        check($sformatf("w8_a%0d_s%0d", av, s), 32'(y8));
      end
    end
    a8 = 1'b1; s8 = 3'd5;
    push(32'h20);
    settle();
    check("w8_a1_s5_const", 32'(y8));

    // 6 lanes, 4-bit data: includes out-of-range selects 6 and 7.
    a6 = 4'hA;
    for (int s = 0; s < 8; s++) begin
      s6 = 3'(s);
      push(model(6, 4, 4'hA, s));
      settle();
      check($sformatf("w6_s%0d", s), 32'(y6));
    end
    s6 = 3'd3;
    push(32'h0000A000);
    settle();
    check("w6_s3_const", 32'(y6));

    // Reset with sel=1, a=1 held: immediate clear, no clock involved.
    a4 = 1'b1; s4 = 2'd1;
    push(32'h2);
    settle();
    check("rst_pre", 32'(y4));
    #1 rst_n = 1'b0;
    #1;
    push(32'd0); check("rst_async_clear", 32'(y4));
    rst_n = 1'b1;
    #1;
`ifdef DEMUX_N_OUT_REG_EN
    push(32'd0); check("rst_release_hold", 32'(y4));
    @(posedge clk);
    #1;
    push(32'h2); check("rst_release_edge", 32'(y4));
`else
    push(32'h2); check("rst_release_comb", 32'(y4));
`endif

    // Latency: sel 0 -> 2 just after an edge.
    a4 = 1'b1; s4 = 2'd0;
    push(32'h1);
    settle();
    check("lat_pre", 32'(y4));
    s4 = 2'd2;
`ifdef DEMUX_N_OUT_REG_EN
    #2;
    push(32'h1); check("lat_hold", 32'(y4));
    @(posedge clk);
    #1;
    push(32'h4); check("lat_update", 32'(y4));
`else
    #1;
    push(32'h4); check("lat_comb", 32'(y4));
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
